lfsr_stream_peripheral: RTL and testbench
=========================================

LFSR_STREAM_PERIPHERAL -- requirements
Module: lfsr_stream_peripheral

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent LFSR channels (1..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the prefetch words per channel (power of two, 2..16).
REQ-003 The block SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port bus, bus_if.slave, -, with the signals listed in REQ-006 to REQ-013.
REQ-006 The block SHALL have bus.req, input, 1, meaning request.
REQ-007 The block SHALL have bus.we, input, 1, meaning write enable.
REQ-008 The block SHALL have bus.addr, input, 32, meaning the byte address; only bits [7:0] are decoded.
REQ-009 The block SHALL have bus.wdata, input, 32, meaning write data.
REQ-010 The block SHALL have bus.gnt, output, 1, meaning grant.
REQ-011 The block SHALL have bus.rvalid, output, 1, meaning response valid.
REQ-012 The block SHALL have bus.rdata, output, 32, meaning read data.
REQ-013 The block SHALL have bus.err, output, 1, meaning response error.

Function
REQ-014 bus.gnt SHALL equal bus.req combinationally; every granted request SHALL get exactly one response cycle (rvalid=1) in the following cycle.
REQ-015 Address map SHALL be: addr[7:4]=channel c, addr[3:0]: 0x0 DATA (read), 0x4 SEED_LO (write), 0x8 SEED_MID (write), 0xC SEED_HI (write); addr[7:0]=0xF0 STATUS (read/write).
REQ-016 Accesses to c>=NUM_CH (except STATUS), unaligned offsets, reads of SEED_*, or writes to DATA SHALL respond with err=1 and rdata=0, with no side effect.
REQ-017 Each channel SHALL hold an 80-bit state s[79:0], a staging register for SEED_LO/SEED_MID, an enable flag and a FIFO_DEPTH x 32 FIFO.
REQ-018 A SEED_LO or SEED_MID write SHALL update only the staging bits [31:0] or [63:32] respectively.
REQ-019 A SEED_HI write at cycle T SHALL load s = {wdata[15:0], staged[63:0]}, flush the channel FIFO, and set enable, all visible at T+1.
REQ-020 The LFSR step SHALL be a Fibonacci shift with new bit s[79]' = s0^s13^s23^s38^s51^s62 and s[k]' = s[k+1].
REQ-021 One word SHALL equal the current state's bits [31:0] (s0 at bit 0), after which the state advances 32 steps in a single cycle.
REQ-022 An enabled channel SHALL push one word per cycle while its FIFO is not full or is being popped in the same cycle.
REQ-023 After a SEED_HI write at T, the first word SHALL be in the FIFO at T+2.
REQ-024 A DATA read of a non-empty FIFO SHALL return the head word next cycle with err=0 and pop it.
REQ-025 A DATA read of an empty FIFO SHALL return rdata=0, err=1 and set the sticky UNDERFLOW[c] bit.
REQ-026 A simultaneous push and pop SHALL leave the fill level unchanged.
REQ-027 A SEED_HI write SHALL take precedence over a same-cycle push; the pre-flush head SHALL be returned to any same-cycle read of the same channel.
REQ-028 A STATUS read SHALL return bit c = FIFO[c] non-empty and bit 8+c = UNDERFLOW[c], with unused bits 0.
REQ-029 A STATUS write SHALL clear UNDERFLOW[c] for each wdata bit 8+c that is 1.
REQ-030 A write SHALL respond with rdata=0 and err=0 unless REQ-016 applies.

Reset
REQ-031 While rst_ni=0, the block SHALL hold rvalid=0, err=0 and rdata=0, with all states, staging registers, enables, FIFOs and UNDERFLOW bits cleared.
REQ-032 A reset asserted mid-operation SHALL discard any pending response and all FIFO contents, and channels SHALL stay disabled until reseeded.

Verification
REQ-033 Reset, then read DATA ch0 -> rvalid next cycle, rdata=0, err=1; STATUS=0x00000100.
REQ-034 Write ch0 SEED_LO=0x00000001, SEED_MID=0, SEED_HI=0, then three DATA reads -> 0x00000001, 0x00000000, 0x00010000, each with err=0.
REQ-035 Seed ch1 all-zero, wait 10 cycles -> STATUS bit1=1; reads return 0x00000000 and the FIFO refills to FIFO_DEPTH without overflow.
REQ-036 Seed ch0, let its FIFO fill, reseed with SEED_HI in the same cycle as a DATA read -> the read returns the old head; the next read returns the new seed's first word.
REQ-037 Read addr 0x20 with NUM_CH=2, and write DATA ch0 -> both responses err=1, rdata=0; FIFO level unchanged.
REQ-038 Write STATUS=0x00000100 after an underflow -> STATUS bit8 reads 0; assert rst_ni mid-stream -> STATUS=0 and rvalid=0.

Source files
------------

// File: rtl/lfsr_stream_peripheral_if.sv
// Register bus: grant is combinational, each granted request gets one response cycle.
// No backpressure beyond req/gnt; responses always arrive exactly one cycle later.
interface bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
endinterface

// File: rtl/lfsr_stream_peripheral.sv
// Multi-channel 80-bit LFSR word generator with per-channel prefetch FIFOs behind a register bus.
// Bus response one cycle after request; generators stall only when their FIFO is full and not popped.

// Generic FIFO, zero-latency head; write accepted when not full or when popped the same cycle.
// flush empties the FIFO and wins over a same-cycle write or read.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_wr, do_rd;

    assign rd_vld = cnt_q != '0;
    assign rd_dat = mem_q[rd_ptr_q];
    assign do_rd  = rd_vld && rd_rdy;
    assign wr_rdy = (cnt_q != (AW+1)'(DEPTH)) || do_rd;
    assign do_wr  = wr_vld && wr_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

module lfsr_stream_peripheral #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    bus_if.slave bus
);
    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    logic [3:0]             ch_sel, off;
    logic                   is_status, ch_ok;
    logic                   data_rd, seed_wr, status_rd, status_wr;
    logic [NUM_CH-1:0]      fifo_vld, wr_rdy, en_vec, udf_vec;
    logic [NUM_CH-1:0][31:0] head_dat;
    logic [31:0]            head_sel, status_vec, rdata_d;
    logic                   sel_vld, err_d;
    logic                   rvalid_q, err_q;
    logic [31:0]            rdata_q;
    logic                   unused_addr_hi;

    // 32 Fibonacci steps folded into one cycle
    function automatic logic [79:0] advance32(input logic [79:0] s);
        logic [79:0] t;
        t = s;
        for (int i = 0; i < 32; i++)
            t = {t[0] ^ t[13] ^ t[23] ^ t[38] ^ t[51] ^ t[62], t[79:1]};
        return t;
    endfunction

    assign ch_sel         = bus.addr[7:4];
    assign off            = bus.addr[3:0];
    assign unused_addr_hi = ^bus.addr[31:8];
    assign is_status      = bus.addr[7:0] == 8'hF0;
    assign ch_ok          = {1'b0, ch_sel} < NUM_CH_L;
    assign data_rd        = bus.req && !bus.we && ch_ok && (off == 4'h0);
    assign seed_wr        = bus.req && bus.we && ch_ok &&
                            (off == 4'h4 || off == 4'h8 || off == 4'hC);
    assign status_rd      = bus.req && !bus.we && is_status;
    assign status_wr      = bus.req && bus.we && is_status;
    assign bus.gnt        = bus.req;

    always_comb begin
        head_sel   = '0;
        sel_vld    = 1'b0;
        status_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c)) begin
                head_sel = head_dat[c];
                sel_vld  = fifo_vld[c];
            end
            status_vec[c]     = fifo_vld[c];
            status_vec[8 + c] = udf_vec[c];
        end
    end

    // Anything that is not a legal data read, seed write or status access is an error
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (status_rd) begin
            rdata_d = status_vec;
        end else if (data_rd) begin
            if (sel_vld) rdata_d = head_sel;
            else         err_d   = 1'b1;
        end else if (!(seed_wr || status_wr)) begin
            err_d = bus.req;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [79:0] state_q;
        logic [63:0] stage_q;
        logic        en_q, udf_q, hit, pop, seed_hi, push;

        assign hit        = ch_sel == 4'(c);
        assign pop        = data_rd && hit && fifo_vld[c];
        assign seed_hi    = seed_wr && hit && (off == 4'hC);
        assign push       = en_q && !seed_hi;
        assign en_vec[c]  = en_q;
        assign udf_vec[c] = udf_q;

        fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .flush  (seed_hi),
            .wr_vld (push),
            .wr_rdy (wr_rdy[c]),
            .wr_dat (state_q[31:0]),
            .rd_vld (fifo_vld[c]),
            .rd_rdy (pop),
            .rd_dat (head_dat[c])
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= '0;
                stage_q <= '0;
                en_q    <= 1'b0;
                udf_q   <= 1'b0;
            end else begin
                if (seed_hi) begin
                    state_q <= {bus.wdata[15:0], stage_q};
                    en_q    <= 1'b1;
                end else if (push && wr_rdy[c]) begin
                    state_q <= advance32(state_q);
                end
                if (seed_wr && hit && off == 4'h4) stage_q[31:0]  <= bus.wdata;
                if (seed_wr && hit && off == 4'h8) stage_q[63:32] <= bus.wdata;
                if (data_rd && hit && !fifo_vld[c])
                    udf_q <= 1'b1;
                else if (status_wr && bus.wdata[8 + c])
                    udf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= bus.req;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_lfsr_stream_peripheral.sv
// Directed plus random bus traffic checked against a bit-stream/fill-level model of the peripheral.
module tb_lfsr_stream_peripheral;
    localparam int NCH = 2;
    localparam int DEP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_if bus();

    lfsr_stream_peripheral #(.NUM_CH(NCH), .FIFO_DEPTH(DEP)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [79:0] m_seed  [NCH];
    logic [63:0] m_stage [NCH];
    bit          m_en    [NCH];
    int          m_level [NCH];
    int          m_next  [NCH];
    bit          m_udf   [NCH];
    logic        exp_rvalid, exp_err;
    logic [31:0] exp_rdata, last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Word k of a seed is bits [32k+31:32k] of the sequence x[n+80] = x[n]^x[n+13]^x[n+23]^x[n+38]^x[n+51]^x[n+62]
    function automatic logic [31:0] word_at(input logic [79:0] seed, input int k);
        bit          x[];
        int          len;
        logic [31:0] w;
        len = 32 * k + 32;
        if (len < 80) len = 80;
        x = new[len];
        for (int n = 0; n < 80; n++) x[n] = seed[n];
        for (int n = 80; n < len; n++)
            x[n] = x[n-80] ^ x[n-67] ^ x[n-57] ^ x[n-42] ^ x[n-29] ^ x[n-18];
        for (int j = 0; j < 32; j++) w[j] = x[32 * k + j];
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_seed[c]  = '0;
            m_stage[c] = '0;
            m_en[c]    = 1'b0;
            m_level[c] = 0;
            m_next[c]  = 0;
            m_udf[c]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int         ch, pop_ch, seed_ch;
        logic [3:0] off;
        ch = int'(a[7:4]);
        off = a[3:0];
        pop_ch = -1;
        seed_ch = -1;
        exp_rvalid = r;
        exp_rdata = '0;
        exp_err = 1'b0;
        if (r) begin
            if (a[7:0] == 8'hF0) begin
                if (w) begin
                    for (int c = 0; c < NCH; c++) if (d[8 + c]) m_udf[c] = 1'b0;
                end else begin
                    for (int c = 0; c < NCH; c++) begin
                        exp_rdata[c]     = m_level[c] > 0;
                        exp_rdata[8 + c] = m_udf[c];
                    end
                end
            end else if (ch >= NCH || off[1:0] != 2'b00) begin
                exp_err = 1'b1;
            end else if (off == 4'h0) begin
                if (w) exp_err = 1'b1;
                else if (m_level[ch] > 0) begin
                    exp_rdata = word_at(m_seed[ch], m_next[ch]);
                    m_next[ch]++;
                    pop_ch = ch;
                end else begin
                    exp_err = 1'b1;
                    m_udf[ch] = 1'b1;
                end
            end else if (!w) begin
                exp_err = 1'b1;
            end else if (off == 4'h4) m_stage[ch][31:0] = d;
            else if (off == 4'h8) m_stage[ch][63:32] = d;
            else seed_ch = ch;
        end
        for (int c = 0; c < NCH; c++) begin
            if (c == seed_ch) begin
                m_seed[c]  = {d[15:0], m_stage[c]};
                m_en[c]    = 1'b1;
                m_level[c] = 0;
                m_next[c]  = 0;
            end else if (m_en[c]) begin
                if (m_level[c] < DEP || c == pop_ch) m_level[c]++;
                if (c == pop_ch) m_level[c]--;
            end
        end
    endtask

    // Called at a negedge; drives one bus cycle and checks its response at the next negedge
    task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        bus.req = r;
        bus.we = w;
        bus.addr = a;
        bus.wdata = d;
        #1;
        check({tag, ".gnt"}, {31'd0, bus.gnt}, {31'd0, r});
        @(posedge clk);
        model_step(r, w, a, d);
        @(negedge clk);
        check({tag, ".rvalid"}, {31'd0, bus.rvalid}, {31'd0, exp_rvalid});
        check({tag, ".rdata"}, bus.rdata, exp_rdata);
        check({tag, ".err"}, {31'd0, bus.err}, {31'd0, exp_err});
        last_rdata = bus.rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 32'h0, 32'h0, "idle");
    endtask

    initial begin
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst.rdata", bus.rdata, 32'd0);
        check("rst.err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty read underflows and sets the sticky bit
        op(1, 0, 32'h00, 0, "rd_empty");
        op(1, 0, 32'hF0, 0, "status_udf");
        check("status_udf.const", last_rdata, 32'h0000_0100);

        // Known seed: first three words
        op(1, 1, 32'h04, 32'h0000_0001, "seed_lo");
        op(1, 1, 32'h08, 32'h0, "seed_mid");
        op(1, 1, 32'h0C, 32'h0, "seed_hi");
        idle(1);
        op(1, 0, 32'h00, 0, "w0");
        check("w0.const", last_rdata, 32'h0000_0001);
        op(1, 0, 32'h00, 0, "w1");
        check("w1.const", last_rdata, 32'h0000_0000);
        op(1, 0, 32'h00, 0, "w2");
        check("w2.const", last_rdata, 32'h0001_0000);

        // Clearing the underflow flag
        op(1, 1, 32'hF0, 32'h0000_0100, "status_clr");
        op(1, 0, 32'hF0, 0, "status_after_clr");
        check("status_after_clr.bit8", {31'd0, last_rdata[8]}, 32'd0);

        // All-zero seed on ch1 keeps streaming zeros
        op(1, 1, 32'h14, 0, "z_lo");
        op(1, 1, 32'h18, 0, "z_mid");
        op(1, 1, 32'h1C, 0, "z_hi");
        idle(10);
        op(1, 0, 32'hF0, 0, "z_status");
        check("z_status.bit1", {31'd0, last_rdata[1]}, 32'd1);
        for (int i = 0; i < 6; i++) op(1, 0, 32'h10, 0, "z_rd");
        idle(6);
        op(1, 0, 32'hF0, 0, "z_refill");

        // Reseed right behind a read of a full FIFO
        op(1, 1, 32'h04, 32'hDEAD_BEEF, "rs_lo");
        op(1, 1, 32'h08, 32'h0BAD_F00D, "rs_mid");
        op(1, 0, 32'h00, 0, "rs_old_head");
        op(1, 1, 32'h0C, 32'h0000_1234, "rs_hi");
        idle(1);
        op(1, 0, 32'h00, 0, "rs_new_head");
        check("rs_new_head.const", last_rdata, 32'hDEAD_BEEF);

        // Illegal accesses have no side effect
        idle(4);
        op(1, 0, 32'h20, 0, "bad_ch");
        op(1, 1, 32'h00, 32'hFFFF_FFFF, "wr_data");
        op(1, 0, 32'hF0, 0, "bad_status");
        op(1, 0, 32'h00, 0, "bad_next_word");

        for (int i = 0; i < 400; i++) begin
            int          kind, ch;
            logic        r, w;
            logic [31:0] a, d;
            kind = $urandom_range(0, 11);
            ch = $urandom_range(0, NCH - 1);
            d = $urandom;
            a = $urandom;
            r = 1'b1;
            w = 1'b1;
            case (kind)
                0, 1, 2, 3, 4: begin a[7:0] = {4'(ch), 4'h0}; w = 1'b0; end
                5:  a[7:0] = {4'(ch), 4'h4};
                6:  a[7:0] = {4'(ch), 4'h8};
                7:  a[7:0] = {4'(ch), 4'hC};
                8:  begin a[7:0] = 8'hF0; w = 1'b0; end
                9:  a[7:0] = 8'hF0;
                10: r = 1'b0;
                default: w = 1'($urandom_range(0, 1));
            endcase
            op(r, w, a, d, "rnd");
        end

        // Reset landing on a pending response
        bus.req = 1'b1;
        bus.we = 1'b0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.req = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst.rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("mid_rst.rdata", bus.rdata, 32'd0);
        check("mid_rst.err", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(1, 0, 32'hF0, 0, "post_rst_status");
        check("post_rst_status.const", last_rdata, 32'd0);
        idle(3);
        op(1, 0, 32'h00, 0, "post_rst_rd0");
        op(1, 0, 32'h10, 0, "post_rst_rd1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
